// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index type and pipeline sequencer state.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pctrl_state_t;

  // Per-stage strobes, bit order matches the stage order front to back.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } strobes_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the stage registers and enable/flush strobes back to them.
interface pipeline_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_ren;
  logic             mem_wen;
  logic             mem_redirect;
  logic             mem_halt;
  logic             wb_halt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_wsel;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_ren, mem_wen, mem_redirect, mem_halt, wb_halt,
           ex_memread, ex_wsel, id_rs, id_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_ren, mem_wen, mem_redirect, mem_halt, wb_halt,
           ex_memread, ex_wsel, id_rs, id_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds an operand of the instruction in ID.
module load_use_detect
  import cpu_types_pkg::*;
#(
  parameter int REG_W = $bits(regbits_t)
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  // r0 is hardwired to zero, so a load targeting it can never be a dependency.
  assign hazard = ex_memread && (ex_wsel != '0) &&
                  ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: stage enables/flushes, halt drain, stall counter.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = $bits(regbits_t)
) (
  input  logic          CLK,
  input  logic          RST,
  pipeline_ctrl_if.slave bus
);

  pctrl_state_t     state_q, state_d;
  pctrl_state_t     rr_state;
  strobes_t         rr, st;
  logic             hazard;
  logic             dwait;
  logic             halt_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .ex_memread (bus.ex_memread),
    .ex_wsel    (bus.ex_wsel),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .hazard     (hazard)
  );

  assign dwait = (bus.mem_ren || bus.mem_wen) && !bus.dhit;

  // Strobes once the data memory is no longer blocking; shared by RUN and the DWAIT exit cycle.
  always_comb begin
    rr       = '0;
    rr_state = RUN;
    if (bus.mem_halt) begin
      rr          = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                      memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                      exmem_flush: 1'b0};
      rr_state    = DRAIN;
    end else if (bus.mem_redirect) begin
      rr          = '1;
    end else if (hazard) begin
      rr.idex_en    = 1'b1;
      rr.exmem_en   = 1'b1;
      rr.memwb_en   = 1'b1;
      rr.idex_flush = 1'b1;
    end else if (!bus.ihit) begin
      rr.ifid_en    = 1'b1;
      rr.idex_en    = 1'b1;
      rr.exmem_en   = 1'b1;
      rr.memwb_en   = 1'b1;
      rr.ifid_flush = 1'b1;
    end else begin
      rr = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
             memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
    end
  end

  always_comb begin
    st      = '0;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dwait) begin
          state_d = DWAIT;
        end else begin
          st      = rr;
          state_d = rr_state;
        end
      end
      DWAIT: begin
        if (bus.dhit) begin
          st      = rr;
          state_d = rr_state;
        end
      end
      DRAIN: begin
        st = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
               memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0};
      end
      HALTED: st = '0;
      default: state_d = RUN;
    endcase
    if (bus.wb_halt) state_d = HALTED;
    if (RST)         st      = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!st.pc_en && (state_q != HALTED) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= (state_d == HALTED);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_en       = st.pc_en;
  assign bus.ifid_en     = st.ifid_en;
  assign bus.idex_en     = st.idex_en;
  assign bus.exmem_en    = st.exmem_en;
  assign bus.memwb_en    = st.memwb_en;
  assign bus.ifid_flush  = st.ifid_flush;
  assign bus.idex_flush  = st.idex_flush;
  assign bus.exmem_flush = st.exmem_flush;
  assign bus.halt        = halt_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: driver queues expectations, monitor checks at negedge.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;

  // Control vector bits: {ihit, dhit, mem_ren, mem_wen, mem_redirect, mem_halt, wb_halt, ex_memread}
  localparam logic [7:0] IH = 8'h80, DH = 8'h40, REN = 8'h20, WEN = 8'h10;
  localparam logic [7:0] RD = 8'h08, MH = 8'h04, WH = 8'h02, EMR = 8'h01;

  // Strobe bits: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] FULL   = 8'hFF;
  localparam logic [7:0] O_NONE = 8'b00000000;
  localparam logic [7:0] O_RUN  = 8'b11111000;
  localparam logic [7:0] O_RED  = 8'b11111111;
  localparam logic [7:0] O_LU   = 8'b00011010, M_LU = 8'b11011111;
  localparam logic [7:0] O_IM   = 8'b00111100, M_IM = 8'b10111111;
  localparam logic [7:0] O_DR   = 8'b00011110, M_DR = 8'b10011111;

  typedef struct {
    string      nm;
    logic [7:0] exp;
    logic [7:0] mask;
    int         cnt;
    logic       hlt;
  } exp_t;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic vec(input string nm, input logic r, input logic [7:0] ctl,
                     input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [7:0] ex, input logic [7:0] mk, input int cnt,
                     input logic hlt);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = r;
    {bus.ihit, bus.dhit, bus.mem_ren, bus.mem_wen, bus.mem_redirect,
     bus.mem_halt, bus.wb_halt, bus.ex_memread} = ctl;
    bus.ex_wsel = ws;
    bus.id_rs   = rs;
    bus.id_rt   = rt;
    e.nm   = nm;
    e.exp  = ex;
    e.mask = mk;
    e.cnt  = cnt;
    e.hlt  = hlt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    vec("rst", 1'b1, 8'h00, 5'd0, 5'd0, 5'd0, O_NONE, FULL, 0, 1'b0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
        checks++;
        if ((got & e.mask) != (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s strobes got %b want %b (mask %b)", e.nm, got, e.exp, e.mask);
        end
        checks++;
        if (bus.halt !== e.hlt) begin
          errors++;
          $display("FAIL %s halt got %b want %b", e.nm, bus.halt, e.hlt);
        end
        if (e.cnt >= 0) begin
          checks++;
          if (int'(bus.stall_cnt) != e.cnt) begin
            errors++;
            $display("FAIL %s stall_cnt got %0d want %0d", e.nm, bus.stall_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit drained;
    RST = 1'b1;
    {bus.ihit, bus.dhit, bus.mem_ren, bus.mem_wen, bus.mem_redirect,
     bus.mem_halt, bus.wb_halt, bus.ex_memread} = 8'h00;
    bus.ex_wsel = '0;
    bus.id_rs   = '0;
    bus.id_rt   = '0;

    // Reset asserted mid-DWAIT
    do_reset();
    vec("rst_dw0", 1'b0, IH | REN, 5'd0, 5'd0, 5'd0, O_NONE, FULL, 0, 1'b0);
    vec("rst_dw1", 1'b0, IH | REN, 5'd0, 5'd0, 5'd0, O_NONE, FULL, 1, 1'b0);
    vec("rst_mid", 1'b1, IH | REN, 5'd0, 5'd0, 5'd0, O_NONE, FULL, 0, 1'b0);
    vec("rst_rel", 1'b0, IH,       5'd0, 5'd0, 5'd0, O_RUN,  FULL, 0, 1'b0);

    // Load-use
    do_reset();
    vec("lu_rt",   1'b0, IH | EMR, 5'd8, 5'd3, 5'd8, O_LU,  M_LU, 0, 1'b0);
    vec("lu_post", 1'b0, IH,       5'd0, 5'd0, 5'd0, O_RUN, FULL, 1, 1'b0);
    vec("lu_r0",   1'b0, IH | EMR, 5'd0, 5'd0, 5'd0, O_RUN, FULL, 1, 1'b0);
    vec("lu_rs",   1'b0, IH | EMR, 5'd8, 5'd8, 5'd2, O_LU,  M_LU, 1, 1'b0);
    vec("lu_nodep",1'b0, IH | EMR, 5'd8, 5'd4, 5'd5, O_RUN, FULL, 2, 1'b0);
    vec("lu_end",  1'b0, IH,       5'd0, 5'd0, 5'd0, O_RUN, FULL, 2, 1'b0);

    // Data memory wait
    do_reset();
    vec("dw_0",    1'b0, IH | REN,      5'd0, 5'd0, 5'd0, O_NONE, FULL, 0, 1'b0);
    vec("dw_1",    1'b0, IH | REN,      5'd0, 5'd0, 5'd0, O_NONE, FULL, 1, 1'b0);
    vec("dw_2",    1'b0, IH | REN,      5'd0, 5'd0, 5'd0, O_NONE, FULL, 2, 1'b0);
    vec("dw_hit",  1'b0, IH | REN | DH, 5'd0, 5'd0, 5'd0, O_RUN,  FULL, 3, 1'b0);
    vec("dw_run",  1'b0, IH,            5'd0, 5'd0, 5'd0, O_RUN,  FULL, 3, 1'b0);
    vec("dw_st0",  1'b0, IH | WEN,      5'd0, 5'd0, 5'd0, O_NONE, FULL, 3, 1'b0);
    vec("dw_sthit",1'b0, IH | WEN | DH, 5'd0, 5'd0, 5'd0, O_RUN,  FULL, 4, 1'b0);
    vec("dw_end",  1'b0, IH,            5'd0, 5'd0, 5'd0, O_RUN,  FULL, 4, 1'b0);

    // Redirect priority, redirect held through a data wait, and I-cache miss
    do_reset();
    vec("red_lu",   1'b0, IH | RD | EMR,     5'd8, 5'd1, 5'd8, O_RED, FULL, 0, 1'b0);
    vec("red_miss", 1'b0, RD,                5'd0, 5'd0, 5'd0, O_RED, FULL, 0, 1'b0);
    vec("red_dw",   1'b0, IH | RD | REN,     5'd0, 5'd0, 5'd0, O_NONE, FULL, 0, 1'b0);
    vec("red_dhit", 1'b0, IH | RD | REN | DH,5'd0, 5'd0, 5'd0, O_RED, FULL, 1, 1'b0);
    vec("red_run",  1'b0, IH,                5'd0, 5'd0, 5'd0, O_RUN, FULL, 1, 1'b0);
    vec("imiss",    1'b0, 8'h00,             5'd0, 5'd0, 5'd0, O_IM,  M_IM, 1, 1'b0);
    vec("imiss_end",1'b0, IH,                5'd0, 5'd0, 5'd0, O_RUN, FULL, 2, 1'b0);

    // Halt drain
    do_reset();
    vec("h_run",   1'b0, IH,      5'd0, 5'd0, 5'd0, O_RUN, FULL, 0, 1'b0);
    vec("h_mem",   1'b0, IH | MH, 5'd0, 5'd0, 5'd0, O_DR,  M_DR, 0, 1'b0);
    vec("h_wb",    1'b0, IH | WH, 5'd0, 5'd0, 5'd0, O_DR,  M_DR, 1, 1'b0);
    for (int i = 0; i < 10; i++)
      vec($sformatf("h_halted%0d", i), 1'b0, IH, 5'd0, 5'd0, 5'd0, O_NONE, FULL, 2, 1'b1);

    // Saturation of the 4-bit stall counter
    do_reset();
    for (int i = 0; i < 20; i++)
      vec($sformatf("sat%0d", i), 1'b0, 8'h00, 5'd0, 5'd0, 5'd0, O_IM, M_IM,
          (i > 15) ? 15 : i, 1'b0);
    vec("sat_hold", 1'b0, IH, 5'd0, 5'd0, 5'd0, O_RUN, FULL, 15, 1'b0);

    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      @(negedge CLK);
      #1;
      drained = (sb.size() == 0);
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain scoreboard left %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It generates per-stage enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable. It resolves data-memory wait, branch/jump redirect, load-use hazards and I-cache miss bubbles, and it drains the pipe on halt. It sits beside the stage registers and the hazard inputs come from their outputs. A saturating stall counter is exported for performance reporting.

Parameters:
CNT_W, 16, width of stall cycle counter
REG_W, 5, register index width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_ren  in  1  EX/MEM output: load in MEM stage
mem_wen  in  1  EX/MEM output: store in MEM stage
mem_redirect  in  1  EX/MEM output: taken branch, jump or jr resolved
mem_halt  in  1  EX/MEM output: halt in MEM stage
wb_halt  in  1  MEM/WB output: halt in WB stage
ex_memread  in  1  ID/EX output: load in EX stage
ex_wsel  in  REG_W  ID/EX output: destination register
id_rs  in  REG_W  IF/ID output: rs field
id_rt  in  REG_W  IF/ID output: rt field
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP, opcode ADDI to r0, all controls 0)
halt  out  1  sticky CPU halted
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 while not HALTED

Behaviour:
- FSM states: RUN, DWAIT, DRAIN, HALTED. All outputs are combinational from state and inputs, except halt and stall_cnt, which are registered.
- While RST is high: state=RUN, halt=0, stall_cnt=0. All enables and flushes are forced to 0 combinationally. Reset asserted mid-DWAIT or mid-DRAIN aborts to RUN immediately.
- Stage priority in RUN is highest first:
  1. dmem wait: (mem_ren|mem_wen) and !dhit. All enables=0, no flush. Next state is DWAIT.
  2. redirect: mem_redirect=1. pc_en=1 and all enables=1. ifid_flush=idex_flush=exmem_flush=1. This overrides load-use and ihit.
  3. load-use: ex_memread and ex_wsel!=0 and (ex_wsel==id_rs or ex_wsel==id_rt). pc_en=0, ifid_en=0, idex_flush=1. exmem_en and memwb_en=1.
  4. imiss: !ihit. pc_en=0, ifid_flush=1. Downstream enables=1.
  5. otherwise: all enables=1, no flush.
- DWAIT: all enables=0 until dhit. In the dhit cycle, apply the RUN rules 2-5 with rule 1 treated as satisfied, then go to RUN. Total latency equals memory latency with no extra cycle.
- RUN with mem_halt=1 and not in dmem wait: go to DRAIN. In that cycle pc_en=0, ifid_flush=1 and idex_flush=1. exmem_en and memwb_en=1.
- DRAIN: pc_en=0. IF/ID and ID/EX stay flushed. exmem_en and memwb_en=1. When wb_halt=1, go to HALTED at the next edge.
- HALTED: all enables=0, no flushes, halt=1. Remains until RST.
- wb_halt=1 in any non-reset state forces HALTED, with a registered halt=1 next cycle.
- stall_cnt increments on each rising edge where pc_en=0 and state!=HALTED. It saturates at 2^CNT_W-1 with no wrap.
- Simultaneous events follow priority. If dmem wait and redirect coincide, the redirect is held until dhit and is then applied in the dhit cycle. The redirect source is frozen, so the strobe is still present.
- A load-use hazard against r0 never stalls.

Decomposition:
- cpu_types_pkg gains pctrl_state_t (enum RUN, DWAIT, DRAIN, HALTED) and reuses the existing regbits_t.
- One combinational sub-module, load_use_detect: inputs ex_memread, ex_wsel, id_rs, id_rt; output hazard. Used only here.

Test Plan:
- Reset: RST=1 mid-DWAIT. All enables=0, halt=0, stall_cnt=0. After release with ihit=1 and no hazard, all enables=1 on the first cycle.
- Load-use: ex_memread=1, ex_wsel=8, id_rt=8, ihit=1. Expect pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, and stall_cnt +1. Repeat with ex_wsel=0: no stall.
- Dmem wait: mem_ren=1, dhit=0 for 3 cycles then dhit=1. Expect 3 cycles with all enables=0, then all enables=1 and state RUN; stall_cnt +3.
- Redirect plus load-use: mem_redirect=1 with an active load-use hazard. Expect pc_en=1, ifid/idex/exmem_flush=1, with no load-use stall.
- Halt drain: mem_halt=1 then wb_halt=1 one cycle later. Expect pc_en=0 from the mem_halt cycle and halt=1 after the wb_halt edge. All enables stay 0 for 10 further cycles with ihit=1.
- Saturation: CNT_W=4 and !ihit held for 20 cycles. stall_cnt reaches 15 and holds.
